initial_logic_nvc: RTL and testbench

Parametrised ingress stage of the transmission layer. Buffers incoming words in a main FIFO and pops the head word when its destination virtual channel is not paused. Routes each popped word to one of NUM_VC virtual-channel outputs, using the channel-select field in the word's MSBs. Generalises the fixed two-VC, fixed-depth front end with configurable width, depth and channel count, status thresholds, an occupancy count and sticky error reporting.

---
 rtl/initial_logic_nvc.sv | 183 ++++++++++++++++++
 tb/tb_initial_logic_nvc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/initial_logic_nvc.sv
// -----------------------------------------------------------------------------
// initial_logic_nvc
//
// Ingress stage of the transmission layer. Incoming words go into a show-ahead
// FIFO. Each word carries its destination virtual channel in its top
// VC_SEL_WIDTH bits. The head word is popped when its channel is not paused.
// The popped word is then presented, one cycle later, on that channel's output
// slice together with a single-cycle push strobe.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   reset        - asynchronous reset, active low
//   wr_enable    - write request for data_in
//   data_in      - word to buffer; VC index in data_in[DATA_WIDTH-1 -: VC_SEL_WIDTH]
//   pause_vc     - bit i set means downstream VC i cannot take a word
//   data_out_vc  - flattened per-VC output words, VC i at [i*DATA_WIDTH +: DATA_WIDTH]
//   push_vc      - per-VC push strobe, at most one bit set
//   fifo_count   - current FIFO occupancy, 0..depth
//   full, empty, almost_full, almost_empty - occupancy status
//   error        - sticky: overflow write or invalid VC index popped
// -----------------------------------------------------------------------------
module initial_logic_nvc #(
   parameter int DATA_WIDTH      = 6,
   parameter int ADDR_WIDTH      = 2,
   parameter int NUM_VC          = 2,
   parameter int VC_SEL_WIDTH    = 1,
   parameter int ALMOST_FULL_TH  = 3,
   parameter int ALMOST_EMPTY_TH = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_enable,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic [NUM_VC-1:0]            pause_vc,
   output logic [NUM_VC*DATA_WIDTH-1:0] data_out_vc,
   output logic [NUM_VC-1:0]            push_vc,
   output logic [ADDR_WIDTH:0]          fifo_count,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         error
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_TH_C = CNT_W'(ALMOST_FULL_TH);
   localparam logic [CNT_W-1:0] AE_TH_C = CNT_W'(ALMOST_EMPTY_TH);

   // Storage and state
   logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]        wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0]        rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic [NUM_VC-1:0]            pushVc_q, pushVc_d;
   logic [NUM_VC*DATA_WIDTH-1:0] dataOut_q, dataOut_d;
   logic                         error_q, error_d;

   // Combinational helpers
   logic [DATA_WIDTH-1:0]   headWord;
   logic [VC_SEL_WIDTH-1:0] headVc;
   logic                    headVcValid;
   logic                    headPaused;
   logic                    popEn;
   logic                    wrAccept;
   logic                    overflow;
   logic                    fullFlag;
   logic                    emptyFlag;

   // Status flags come straight from the occupancy count.
   always_comb begin
      fullFlag     = (count_q == DEPTH_C);
      emptyFlag    = (count_q == '0);
      full         = fullFlag;
      empty        = emptyFlag;
      almost_full  = (count_q >= AF_TH_C);
      almost_empty = (count_q <= AE_TH_C) && !emptyFlag;
      fifo_count   = count_q;
   end

   // The head of the FIFO is read combinationally (show-ahead). The channel
   // lookup is a loop rather than a direct index into pause_vc. This keeps
   // select values beyond NUM_VC-1 from reading outside the vector. Such
   // values can occur when NUM_VC is not a power of two; they are reported
   // as invalid instead.
   always_comb begin
      headWord    = mem_q[rdPtr_q];
      headVc      = headWord[DATA_WIDTH-1 -: VC_SEL_WIDTH];
      headVcValid = 1'b0;
      headPaused  = 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (headVc == VC_SEL_WIDTH'(i)) begin
            headVcValid = 1'b1;
            headPaused  = pause_vc[i];
         end
      end
   end

   // Pop when a head exists and its channel is not paused. A head with an
   // invalid channel is always popped so that it cannot block the FIFO.
   // A write to a full FIFO is accepted only when the same cycle frees a slot.
   always_comb begin
      popEn    = !emptyFlag && (!headVcValid || !headPaused);
      wrAccept = wr_enable && (!fullFlag || popEn);
      overflow = wr_enable && fullFlag && !popEn;
   end

   // Next-state for the pointers, the count and the sticky error flag.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      error_d = error_q;

      if (wrAccept) begin
         wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
      end
      if (popEn) begin
         rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
      end

      case ({wrAccept, popEn})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (overflow || (popEn && !headVcValid)) begin
         error_d = 1'b1;
      end
   end

   // Output next-state. Only the slice of the popped word's channel reloads.
   // The other slices keep their last word. An invalid-channel pop matches no
   // slice, so it pushes nothing.
   always_comb begin
      pushVc_d  = '0;
      dataOut_d = dataOut_q;
      for (int i = 0; i < NUM_VC; i++) begin
         if (popEn && (headVc == VC_SEL_WIDTH'(i))) begin
            pushVc_d[i]                              = 1'b1;
            dataOut_d[i*DATA_WIDTH +: DATA_WIDTH] = headWord;
         end
      end
   end

   // Control and output registers. Reset discards all contents and cancels
   // any pending push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         pushVc_q  <= '0;
         dataOut_q <= '0;
         error_q   <= 1'b0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         count_q   <= count_d;
         pushVc_q  <= pushVc_d;
         dataOut_q <= dataOut_d;
         error_q   <= error_d;
      end
   end

   // Word storage has no reset. Its contents are never observed while the
   // count says the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wrAccept) begin
         mem_q[wrPtr_q] <= data_in;
      end
   end

   always_comb begin
      push_vc     = pushVc_q;
      data_out_vc = dataOut_q;
      error       = error_q;
   end

endmodule

// File: tb/tb_initial_logic_nvc.sv
// -----------------------------------------------------------------------------
// tb_initial_logic_nvc
//
// Directed bench for initial_logic_nvc. One instance uses the default
// parameters (two VCs, depth 4). A second instance has three VCs, so that a
// select value with no matching channel can be produced.
// -----------------------------------------------------------------------------
module tb_initial_logic_nvc;

   logic        clk = 1'b0;
   logic        reset;

   // Default-parameter instance
   logic        wrEnable;
   logic [5:0]  dataIn;
   logic [1:0]  pauseVc;
   logic [11:0] dataOutVc;
   logic [1:0]  pushVc;
   logic [2:0]  fifoCount;
   logic        full, empty, almostFull, almostEmpty, error;

   // Three-VC instance
   logic        wrEnable3;
   logic [5:0]  dataIn3;
   logic [2:0]  pauseVc3;
   logic [17:0] dataOutVc3;
   logic [2:0]  pushVc3;
   logic [2:0]  fifoCount3;
   logic        full3, empty3, almostFull3, almostEmpty3, error3;

   int compareCount  = 0;
   int mismatchCount = 0;

   always #5 clk = ~clk;

   initial_logic_nvc dut (
      .clk          (clk),
      .reset        (reset),
      .wr_enable    (wrEnable),
      .data_in      (dataIn),
      .pause_vc     (pauseVc),
      .data_out_vc  (dataOutVc),
      .push_vc      (pushVc),
      .fifo_count   (fifoCount),
      .full         (full),
      .empty        (empty),
      .almost_full  (almostFull),
      .almost_empty (almostEmpty),
      .error        (error)
   );

   initial_logic_nvc #(
      .DATA_WIDTH   (6),
      .ADDR_WIDTH   (2),
      .NUM_VC       (3),
      .VC_SEL_WIDTH (2)
   ) dut3 (
      .clk          (clk),
      .reset        (reset),
      .wr_enable    (wrEnable3),
      .data_in      (dataIn3),
      .pause_vc     (pauseVc3),
      .data_out_vc  (dataOutVc3),
      .push_vc      (pushVc3),
      .fifo_count   (fifoCount3),
      .full         (full3),
      .empty        (empty3),
      .almost_full  (almostFull3),
      .almost_empty (almostEmpty3),
      .error        (error3)
   );

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the default instance's inputs, then advance one edge.
   task automatic applyStimulus(input logic wr, input logic [5:0] data,
                                input logic [1:0] pause);
      wrEnable = wr;
      dataIn   = data;
      pauseVc  = pause;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset     = 1'b0;
      wrEnable  = 1'b0;
      dataIn    = '0;
      pauseVc   = '0;
      wrEnable3 = 1'b0;
      dataIn3   = '0;
      pauseVc3  = '0;

      // Reset then idle
      tick();
      tick();
      reset = 1'b1;
      tick();
      checkOutput("rst_push",  pushVc, 2'b00);
      checkOutput("rst_data",  dataOutVc, 12'h000);
      checkOutput("rst_empty", empty, 1'b1);
      checkOutput("rst_count", fifoCount, 3'd0);
      checkOutput("rst_error", error, 1'b0);
      checkOutput("rst_full",  full, 1'b0);
      checkOutput("rst_ae",    almostEmpty, 1'b0);

      // Basic routing
      applyStimulus(1'b1, 6'b100101, 2'b00);
      checkOutput("br_count1", fifoCount, 3'd1);
      checkOutput("br_ae1",    almostEmpty, 1'b1);
      checkOutput("br_push0",  pushVc, 2'b00);
      applyStimulus(1'b1, 6'b000011, 2'b00);
      checkOutput("br_push_vc1", pushVc, 2'b10);
      checkOutput("br_data_vc1", dataOutVc[11:6], 6'b100101);
      checkOutput("br_count2",   fifoCount, 3'd1);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("br_push_vc0", pushVc, 2'b01);
      checkOutput("br_data_vc0", dataOutVc[5:0], 6'b000011);
      checkOutput("br_hold_vc1", dataOutVc[11:6], 6'b100101);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("br_idle_push", pushVc, 2'b00);
      checkOutput("br_empty",     empty, 1'b1);

      // Head-of-line blocking
      applyStimulus(1'b1, 6'b110000, 2'b10);
      applyStimulus(1'b1, 6'b000001, 2'b10);
      checkOutput("hol_push0", pushVc, 2'b00);
      checkOutput("hol_count", fifoCount, 3'd2);
      applyStimulus(1'b0, 6'b000000, 2'b10);
      checkOutput("hol_push1",  pushVc, 2'b00);
      checkOutput("hol_count1", fifoCount, 3'd2);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("hol_push_vc1", pushVc, 2'b10);
      checkOutput("hol_data_vc1", dataOutVc[11:6], 6'b110000);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("hol_push_vc0", pushVc, 2'b01);
      checkOutput("hol_data_vc0", dataOutVc[5:0], 6'b000001);

      // Full and overflow
      applyStimulus(1'b1, 6'b000001, 2'b11);
      applyStimulus(1'b1, 6'b100010, 2'b11);
      applyStimulus(1'b1, 6'b000011, 2'b11);
      checkOutput("ov_af3",    almostFull, 1'b1);
      checkOutput("ov_full3",  full, 1'b0);
      checkOutput("ov_count3", fifoCount, 3'd3);
      applyStimulus(1'b1, 6'b100100, 2'b11);
      checkOutput("ov_full4",  full, 1'b1);
      checkOutput("ov_count4", fifoCount, 3'd4);
      checkOutput("ov_err4",   error, 1'b0);
      applyStimulus(1'b1, 6'b000101, 2'b11);
      checkOutput("ov_count5", fifoCount, 3'd4);
      checkOutput("ov_err5",   error, 1'b1);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("ov_d1_push", pushVc, 2'b01);
      checkOutput("ov_d1_data", dataOutVc[5:0], 6'b000001);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("ov_d2_push", pushVc, 2'b10);
      checkOutput("ov_d2_data", dataOutVc[11:6], 6'b100010);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("ov_d3_data", dataOutVc[5:0], 6'b000011);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("ov_d4_data", dataOutVc[11:6], 6'b100100);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("ov_d5_push",  pushVc, 2'b00);
      checkOutput("ov_d5_empty", empty, 1'b1);
      checkOutput("ov_err_hold", error, 1'b1);

      // Mid-operation reset clears the sticky error and the contents
      reset = 1'b0;
      tick();
      checkOutput("mr_error", error, 1'b0);
      checkOutput("mr_data",  dataOutVc, 12'h000);
      reset = 1'b1;
      tick();

      // Write at full with a same-cycle pop
      applyStimulus(1'b1, 6'b000111, 2'b11);
      applyStimulus(1'b1, 6'b100001, 2'b11);
      applyStimulus(1'b1, 6'b000010, 2'b11);
      applyStimulus(1'b1, 6'b100011, 2'b11);
      checkOutput("wf_full", full, 1'b1);
      applyStimulus(1'b1, 6'b001100, 2'b00);
      checkOutput("wf_count", fifoCount, 3'd4);
      checkOutput("wf_error", error, 1'b0);
      checkOutput("wf_push",  pushVc, 2'b01);
      checkOutput("wf_data",  dataOutVc[5:0], 6'b000111);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("wf_d4_data", dataOutVc[11:6], 6'b100011);
      applyStimulus(1'b0, 6'b000000, 2'b00);
      checkOutput("wf_last_push", pushVc, 2'b01);
      checkOutput("wf_last_data", dataOutVc[5:0], 6'b001100);
      checkOutput("wf_empty",     empty, 1'b1);

      // Three-VC instance: a valid VC2 word, then an invalid select of 2'b11
      wrEnable3 = 1'b1;
      dataIn3   = 6'b100001;
      tick();
      wrEnable3 = 1'b0;
      tick();
      checkOutput("v3_push", pushVc3, 3'b100);
      checkOutput("v3_data", dataOutVc3[17:12], 6'b100001);
      checkOutput("v3_err0", error3, 1'b0);
      wrEnable3 = 1'b1;
      dataIn3   = 6'b110101;
      tick();
      wrEnable3 = 1'b0;
      checkOutput("inv_count1", fifoCount3, 3'd1);
      tick();
      checkOutput("inv_push",   pushVc3, 3'b000);
      checkOutput("inv_error",  error3, 1'b1);
      checkOutput("inv_count0", fifoCount3, 3'd0);
      checkOutput("inv_hold2",  dataOutVc3[17:12], 6'b100001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
